host_cfg_ctrl: RTL and testbench
================================

HOST_CFG_CTRL -- requirements
Module: host_cfg_ctrl

Interface
REQ-001 The block SHALL have one clock and one reset; the reset SHALL be asynchronous and active-low.
REQ-002 clk  in  1  system clock; all flops on rising edge.
REQ-003 rst_x  in  1  asynchronous active-low reset.
REQ-004 ce_x  in  1  host chip select, active low, asynchronous to clk.
REQ-005 a0  in  1  host address: 1 = command byte, 0 = parameter byte; asynchronous.
REQ-006 wr_x  in  1  host write strobe, active low; the write completes on its rising edge; asynchronous.
REQ-007 dat  in  8  host data bus; asynchronous.
REQ-008 frame_start  in  1  one-clk pulse from the TFT timing generator at the start of each frame.
REQ-009 cfg_hdisp  out  10  active horizontal pixels.
REQ-010 cfg_vdisp  out  10  active lines.
REQ-011 cfg_hbp  out  8  horizontal back porch, in clocks.
REQ-012 cfg_vbp  out  8  vertical back porch, in lines.
REQ-013 cfg_en  out  1  display enable.
REQ-014 cfg_inv  out  1  invert pixel data.
REQ-015 cmd_err  out  1  one-clk pulse on an unknown command.

Function
REQ-016 ce_x, wr_x, a0 and dat SHALL each pass through a 2-flop synchronizer.
REQ-017 A write event SHALL be one clk cycle in which the synchronized wr_x is detected going 0->1 while the synchronized ce_x is 0.
REQ-018 On a write event, a0 and dat SHALL be taken from the same synchronizer stage as wr_x.
REQ-019 The host SHALL hold a0, dat and ce_x stable for at least 4 clk after the wr_x rising edge; this is a documented constraint, not checked by the block.
REQ-020 Command decode state machine states: IDLE, TIMING (parameter counter 0..5), DISP (parameter counter 0..0).
REQ-021 A command write (a0=1) SHALL be accepted in any state and SHALL abort any parameter sequence in progress.
REQ-022 Command 0x40 SHALL move to TIMING with the counter cleared to 0.
REQ-023 Command 0x59 SHALL move to DISP and set staged enable to 1.
REQ-024 Command 0x58 SHALL set staged enable to 0, set pending, and move to IDLE.
REQ-025 Any other command value SHALL pulse cmd_err for one clk, 3 clk after the synchronized wr_x rise, and move to IDLE.
REQ-026 TIMING parameters, in order:
- p0 = hdisp[7:0]
- p1 = hdisp[9:8] from dat[1:0]
- p2 = vdisp[7:0]
- p3 = vdisp[9:8] from dat[1:0]
- p4 = hbp
- p5 = vbp
REQ-027 The unused upper bits of p1 and p3 SHALL be ignored.
REQ-028 Each TIMING parameter SHALL be written into a staging register and SHALL increment the counter.
REQ-029 After p5 the block SHALL set pending and move to IDLE.
REQ-030 An aborted TIMING sequence SHALL leave staging partially written and pending unchanged.
REQ-031 The DISP parameter SHALL set staged inv = dat[0], set pending, and move to IDLE.
REQ-032 A parameter write in IDLE SHALL be ignored.
REQ-033 Active outputs SHALL load from staging only in a clk cycle where frame_start=1 and pending=1; pending SHALL clear in that same cycle.
REQ-034 If frame_start coincides with the write event that sets pending, the commit SHALL occur at the next frame_start.
REQ-035 Staging SHALL not be frozen after pending is set; a later write before the commit SHALL overwrite staging, and the newest values SHALL be committed.
REQ-036 Outputs SHALL be registered and SHALL change only on commit.

Reset
REQ-037 On rst_x=0, regardless of state or any sequence in progress:
- cfg_hdisp=320, cfg_vdisp=240, cfg_hbp=40, cfg_vbp=12
- cfg_en=0, cfg_inv=0, cmd_err=0
- staging set to the same values as the outputs
- pending=0, state=IDLE, synchronizers=idle (ce_x/wr_x=1)
REQ-038 The block SHALL resume operation on the first clk after rst_x deasserts.

Verification
REQ-039 Write 0x40 then 80,02,E0,01,2C,10; pulse frame_start -> hdisp=640, vdisp=480, hbp=44, vbp=16, one cycle after frame_start; no change before it.
REQ-040 Write 0x59 then 0x01, with no frame_start -> cfg_en stays 0; after frame_start -> cfg_en=1, cfg_inv=1.
REQ-041 Write 0x40, 3 parameters, then 0x58, then frame_start -> cfg_en=0 and the timing outputs still at reset values (320/240/40/12).
REQ-042 Write command 0x33 -> cmd_err high for exactly 1 clk; a following parameter write causes no output change.
REQ-043 frame_start in the same cycle as the p5 write event -> no commit; next frame_start commits.
REQ-044 Assert rst_x=0 after p2 of a TIMING sequence -> all outputs at reset values; a following parameter write is ignored.

Source files
------------

// File: rtl/host_cfg_ctrl.sv
// host_cfg_ctrl: host command/parameter port that stages TFT timing config and commits it at frame start
// Ports: clk, rst_x (async active-low); host bus ce_x/a0/wr_x/dat (async, synchronized here);
// frame_start (commit strobe); cfg_* active configuration; cmd_err one-clk pulse on an unknown command.
module host_cfg_ctrl (
  input  logic       clk,
  input  logic       rst_x,
  input  logic       ce_x,
  input  logic       a0,
  input  logic       wr_x,
  input  logic [7:0] dat,
  input  logic       frame_start,
  output logic [9:0] cfg_hdisp,
  output logic [9:0] cfg_vdisp,
  output logic [7:0] cfg_hbp,
  output logic [7:0] cfg_vbp,
  output logic       cfg_en,
  output logic       cfg_inv,
  output logic       cmd_err
);
  typedef enum logic [1:0] {IDLE, TIMING, DISP} state_t;
  state_t     r_state;
  logic [2:0] r_cnt;
  logic [1:0] r_ce_s, r_wr_s, r_a0_s;
  logic [7:0] r_dat_s1, r_dat_s2;
  logic       r_wr_d, r_pend;
  logic [9:0] r_s_hdisp, r_s_vdisp;
  logic [7:0] r_s_hbp, r_s_vbp;
  logic       r_s_en, r_s_inv;
  logic       w_we;
  // a0/dat are read from the second sync stage, aligned with the wr_x edge seen there
  assign w_we = r_wr_s[1] & ~r_wr_d & ~r_ce_s[1];
  always_ff @(posedge clk or negedge rst_x)
    if (!rst_x) begin
      r_state   <= IDLE;
      r_cnt     <= 3'd0;
      r_ce_s    <= 2'b11;
      r_wr_s    <= 2'b11;
      r_a0_s    <= 2'b00;
      r_dat_s1  <= 8'd0;
      r_dat_s2  <= 8'd0;
      r_wr_d    <= 1'b1;
      r_pend    <= 1'b0;
      r_s_hdisp <= 10'd320;
      r_s_vdisp <= 10'd240;
      r_s_hbp   <= 8'd40;
      r_s_vbp   <= 8'd12;
      r_s_en    <= 1'b0;
      r_s_inv   <= 1'b0;
      cfg_hdisp <= 10'd320;
      cfg_vdisp <= 10'd240;
      cfg_hbp   <= 8'd40;
      cfg_vbp   <= 8'd12;
      cfg_en    <= 1'b0;
      cfg_inv   <= 1'b0;
      cmd_err   <= 1'b0;
    end else begin
      r_ce_s   <= {r_ce_s[0], ce_x};
      r_wr_s   <= {r_wr_s[0], wr_x};
      r_a0_s   <= {r_a0_s[0], a0};
      r_dat_s1 <= dat;
      r_dat_s2 <= r_dat_s1;
      r_wr_d   <= r_wr_s[1];
      cmd_err  <= 1'b0;
      // pending is sampled before this cycle's write, so a coinciding write waits for the next frame
      if (frame_start && r_pend) begin
        cfg_hdisp <= r_s_hdisp;
        cfg_vdisp <= r_s_vdisp;
        cfg_hbp   <= r_s_hbp;
        cfg_vbp   <= r_s_vbp;
        cfg_en    <= r_s_en;
        cfg_inv   <= r_s_inv;
        r_pend    <= 1'b0;
      end
      if (w_we && r_a0_s[1]) begin
        case (r_dat_s2)
          8'h40: begin
            r_state <= TIMING;
            r_cnt   <= 3'd0;
          end
          8'h59: begin
            r_state <= DISP;
            r_s_en  <= 1'b1;
          end
          8'h58: begin
            r_s_en  <= 1'b0;
            r_pend  <= 1'b1;
            r_state <= IDLE;
          end
          default: begin
            cmd_err <= 1'b1;
            r_state <= IDLE;
          end
        endcase
      end else if (w_we) begin
        case (r_state)
          TIMING: begin
            case (r_cnt)
              3'd0: r_s_hdisp[7:0] <= r_dat_s2;
              3'd1: r_s_hdisp[9:8] <= r_dat_s2[1:0];
              3'd2: r_s_vdisp[7:0] <= r_dat_s2;
              3'd3: r_s_vdisp[9:8] <= r_dat_s2[1:0];
              3'd4: r_s_hbp        <= r_dat_s2;
              3'd5: r_s_vbp        <= r_dat_s2;
              default: ;
            endcase
            r_cnt <= r_cnt + 3'd1;
            if (r_cnt == 3'd5) begin
              r_pend  <= 1'b1;
              r_state <= IDLE;
            end
          end
          DISP: begin
            r_s_inv <= r_dat_s2[0];
            r_pend  <= 1'b1;
            r_state <= IDLE;
          end
          default: ;
        endcase
      end
    end
endmodule

// File: tb/tb_host_cfg_ctrl.sv
// tb_host_cfg_ctrl: vector table, corner sequences and randomized model check of host_cfg_ctrl
module tb_host_cfg_ctrl;
  typedef struct packed {
    logic [9:0] h;
    logic [9:0] v;
    logic [7:0] hb;
    logic [7:0] vb;
    logic       en;
    logic       inv;
  } cfg_t;
  typedef struct {
    bit         fr;
    logic       a;
    logic [7:0] d;
    cfg_t       exp;
  } vec_t;
  localparam cfg_t RST = {10'd320, 10'd240, 8'd40, 8'd12, 1'b0, 1'b0};
  localparam cfg_t CA  = {10'd640, 10'd480, 8'd44, 8'd16, 1'b0, 1'b0};
  localparam cfg_t CB  = {10'd640, 10'd480, 8'd44, 8'd16, 1'b1, 1'b1};
  localparam cfg_t CC  = {10'd800, 10'd600, 8'd16, 8'd8, 1'b0, 1'b0};
  logic       clk = 0, rst_x = 0, ce_x = 1, a0 = 0, wr_x = 1, frame_start = 0;
  logic [7:0] dat = 0;
  logic [9:0] cfg_hdisp, cfg_vdisp;
  logic [7:0] cfg_hbp, cfg_vbp;
  logic       cfg_en, cfg_inv, cmd_err;
  int         n_chk = 0, n_err = 0;
  int         m_mode, m_cnt;
  bit         m_pend;
  cfg_t       m_stg, m_out;
  vec_t       tv[$];

  host_cfg_ctrl dut (
    .clk(clk), .rst_x(rst_x), .ce_x(ce_x), .a0(a0), .wr_x(wr_x), .dat(dat),
    .frame_start(frame_start), .cfg_hdisp(cfg_hdisp), .cfg_vdisp(cfg_vdisp),
    .cfg_hbp(cfg_hbp), .cfg_vbp(cfg_vbp), .cfg_en(cfg_en), .cfg_inv(cfg_inv),
    .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic chk_out(input string nm, input cfg_t exp);
    cfg_t got;
    got = {cfg_hdisp, cfg_vdisp, cfg_hbp, cfg_vbp, cfg_en, cfg_inv};
    chk(nm, 64'(got), 64'(exp));
  endtask

  // full host write cycle; counts clocks in which cmd_err was seen high
  task automatic hw(input logic a, input logic [7:0] d, output int errs);
    errs = 0;
    @(negedge clk);
    ce_x = 0; a0 = a; dat = d; wr_x = 0;
    repeat (2) begin @(negedge clk); errs += int'(cmd_err); end
    wr_x = 1;
    repeat (6) begin @(negedge clk); errs += int'(cmd_err); end
    ce_x = 1;
    repeat (2) begin @(negedge clk); errs += int'(cmd_err); end
  endtask

  task automatic fr();
    @(negedge clk) frame_start = 1;
    @(negedge clk) frame_start = 0;
  endtask

  task automatic do_reset();
    @(negedge clk) rst_x = 0;
    @(negedge clk) rst_x = 1;
  endtask

  task automatic m_reset();
    m_mode = 0; m_cnt = 0; m_pend = 0; m_stg = RST; m_out = RST;
  endtask

  // mode: 0 idle, 1 collecting the six timing bytes, 2 waiting for the display byte
  task automatic m_write(input logic a, input logic [7:0] d, output int err);
    err = 0;
    if (a) begin
      if (d == 8'h40) begin m_mode = 1; m_cnt = 0; end
      else if (d == 8'h59) begin m_mode = 2; m_stg.en = 1; end
      else if (d == 8'h58) begin m_mode = 0; m_stg.en = 0; m_pend = 1; end
      else begin m_mode = 0; err = 1; end
    end else if (m_mode == 1) begin
      if (m_cnt == 0) m_stg.h = (m_stg.h & 10'h300) | 10'(d);
      if (m_cnt == 1) m_stg.h = (m_stg.h & 10'h0FF) | (10'(d % 4) * 256);
      if (m_cnt == 2) m_stg.v = (m_stg.v & 10'h300) | 10'(d);
      if (m_cnt == 3) m_stg.v = (m_stg.v & 10'h0FF) | (10'(d % 4) * 256);
      if (m_cnt == 4) m_stg.hb = d;
      if (m_cnt == 5) m_stg.vb = d;
      m_cnt++;
      if (m_cnt == 6) begin m_mode = 0; m_pend = 1; end
    end else if (m_mode == 2) begin
      m_stg.inv = d[0]; m_pend = 1; m_mode = 0;
    end
  endtask

  initial begin
    int e, me;
    tv.push_back('{0, 1'b1, 8'h40, RST});
    tv.push_back('{0, 1'b0, 8'h80, RST});
    tv.push_back('{0, 1'b0, 8'h02, RST});
    tv.push_back('{0, 1'b0, 8'hE0, RST});
    tv.push_back('{0, 1'b0, 8'h01, RST});
    tv.push_back('{0, 1'b0, 8'h2C, RST});
    tv.push_back('{0, 1'b0, 8'h10, RST});
    tv.push_back('{1, 1'b0, 8'h00, CA});
    tv.push_back('{0, 1'b1, 8'h59, CA});
    tv.push_back('{0, 1'b0, 8'h01, CA});
    tv.push_back('{1, 1'b0, 8'h00, CB});
    tv.push_back('{1, 1'b0, 8'h00, CB});

    repeat (2) @(negedge clk);
    chk_out("reset_outputs", RST);
    chk("reset_cmd_err", 64'(cmd_err), 64'd0);
    rst_x = 1;

    foreach (tv[i]) begin
      if (tv[i].fr) fr();
      else begin
        hw(tv[i].a, tv[i].d, e);
        chk($sformatf("vec%0d_cmd_err", i), 64'(e), 64'd0);
      end
      chk_out($sformatf("vec%0d_outputs", i), tv[i].exp);
    end

    // aborted timing sequence then disable; partial bytes match the reset values
    do_reset();
    hw(1, 8'h40, e); hw(0, 8'h40, e); hw(0, 8'h01, e); hw(0, 8'hF0, e);
    hw(1, 8'h58, e);
    chk_out("abort_before_frame", RST);
    fr();
    chk_out("abort_after_frame", RST);

    // unknown command: cmd_err exactly one clk, third clk after wr_x rises
    @(negedge clk);
    ce_x = 0; a0 = 1; dat = 8'h33; wr_x = 0;
    repeat (2) @(negedge clk);
    wr_x = 1;
    @(negedge clk) chk("err_clk1", 64'(cmd_err), 64'd0);
    @(negedge clk) chk("err_clk2", 64'(cmd_err), 64'd0);
    @(negedge clk) chk("err_clk3", 64'(cmd_err), 64'd1);
    @(negedge clk) chk("err_clk4", 64'(cmd_err), 64'd0);
    repeat (3) @(negedge clk);
    ce_x = 1;
    hw(0, 8'h55, e);
    fr();
    chk_out("param_after_err", RST);

    // frame_start coinciding with the p5 write event
    hw(1, 8'h40, e); hw(0, 8'h20, e); hw(0, 8'h03, e); hw(0, 8'h58, e); hw(0, 8'h02, e); hw(0, 8'h10, e);
    @(negedge clk);
    ce_x = 0; a0 = 0; dat = 8'h08; wr_x = 0;
    repeat (2) @(negedge clk);
    wr_x = 1;
    repeat (2) @(negedge clk);
    frame_start = 1;
    @(negedge clk) frame_start = 0;
    repeat (4) @(negedge clk);
    ce_x = 1;
    chk_out("coincide_no_commit", RST);
    fr();
    chk_out("coincide_next_commit", CC);

    // reset in the middle of a timing sequence
    hw(1, 8'h40, e); hw(0, 8'h11, e); hw(0, 8'h01, e); hw(0, 8'h22, e);
    @(negedge clk);
    #2 rst_x = 0;
    #1 chk_out("midseq_reset_outputs", RST);
    chk("midseq_reset_cmd_err", 64'(cmd_err), 64'd0);
    @(negedge clk) rst_x = 1;
    hw(0, 8'h77, e);
    fr();
    chk_out("post_reset_param_ignored", RST);

    // randomized traffic against the transaction-level model
    m_reset();
    for (int k = 0; k < 80; k++) begin
      int r;
      logic [7:0] d;
      r = $urandom_range(0, 9);
      d = 8'($urandom);
      if (r < 2) begin
        fr();
        if (m_pend) begin m_out = m_stg; m_pend = 0; end
      end else begin
        logic a;
        a = (r < 6);
        if (r == 2) d = 8'h40;
        if (r == 3) d = 8'h59;
        if (r == 4) d = 8'h58;
        hw(a, d, e);
        m_write(a, d, me);
        chk($sformatf("rnd%0d_cmd_err", k), 64'(e), 64'(me));
      end
      chk_out($sformatf("rnd%0d_outputs", k), m_out);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
